// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared encodings for the memory access sequencer
package mem_seq_pkg;

    localparam int WIDTH_DEF      = 12;
    localparam int FIELD_BITS_DEF = 3;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_INC = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Code 11 is reserved and behaves as a plain read
    function automatic op_e decode_op(input logic [1:0] code);
        case (code)
            2'b01:   return OP_WR;
            2'b10:   return OP_INC;
            default: return OP_RD;
        endcase
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// rtl/mem_seq_if.sv - requester and RAM-port bundle for mem_seq
interface mem_seq_if
    import mem_seq_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int FIELD_BITS = FIELD_BITS_DEF
) ();

    logic [NCH-1:0]            req;
    logic [2*NCH-1:0]          op;
    logic [FIELD_BITS*NCH-1:0] field;
    logic [WIDTH*NCH-1:0]      addr;
    logic [WIDTH*NCH-1:0]      wdata;
    logic [NCH-1:0]            gnt;
    logic                      busy;
    logic                      done;
    logic [NCH-1:0]            done_ch;
    logic [WIDTH-1:0]          rdata;
    logic                      carry;
    logic [FIELD_BITS+WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0]          ram_din;
    logic                      ram_we;
    logic [WIDTH-1:0]          ram_dout;

    modport master (
        output req, op, field, addr, wdata, ram_dout,
        input  gnt, busy, done, done_ch, rdata, carry, ram_addr, ram_din, ram_we
    );

    modport slave (
        input  req, op, field, addr, wdata, ram_dout,
        output gnt, busy, done, done_ch, rdata, carry, ram_addr, ram_din, ram_we
    );

endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - fixed-priority one-hot arbiter, channel 0 wins
module mem_arb #(
    parameter int NCH = 2
) (
    input  logic           en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt
);

    logic taken;

    // Grant the lowest-index active requester while enabled
    always_comb begin
        gnt   = '0;
        taken = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (en && req[i] && !taken) begin
                gnt[i] = 1'b1;
                taken  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - arbitrated read/write/increment sequencer for one RAM port
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int FIELD_BITS = FIELD_BITS_DEF,
    parameter int MAX_FIELD  = 7,
    parameter int NCH        = 2,
    parameter int RD_LAT     = 1
) (
    input logic     clk,
    input logic     reset,
    mem_seq_if.slave bus
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int NF = 1 << FIELD_BITS;

    // One bit per field number: set when that field has memory behind it
    function automatic logic [NF-1:0] field_map();
        logic [NF-1:0] m;
        for (int i = 0; i < NF; i++) m[i] = (i <= MAX_FIELD);
        return m;
    endfunction

    localparam logic [NF-1:0] FIELD_OK = field_map();

    state_e                state;
    op_e                   op_q;
    op_e                   sel_dec;
    logic [NCH-1:0]        own_q;
    logic                  fld_ok_q;
    logic [CW-1:0]         cnt;
    logic [NCH-1:0]        gnt;
    logic [1:0]            sel_op;
    logic [FIELD_BITS-1:0] sel_field;
    logic [WIDTH-1:0]      sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic [WIDTH-1:0]      rd_val;

    mem_arb #(.NCH(NCH)) u_arb (
        .en  (state == ST_IDLE && !reset),
        .req (bus.req),
        .gnt (gnt)
    );

    assign bus.gnt  = gnt;
    assign bus.busy = (state != ST_IDLE);
    assign sel_dec  = decode_op(sel_op);
    // Nonexistent memory reads as zero
    assign rd_val   = fld_ok_q ? bus.ram_dout : '0;

    // Pick the granted channel's request fields (grant is one-hot)
    always_comb begin
        sel_op    = '0;
        sel_field = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (gnt[c]) begin
                sel_op    = bus.op[2*c +: 2];
                sel_field = bus.field[FIELD_BITS*c +: FIELD_BITS];
                sel_addr  = bus.addr[WIDTH*c +: WIDTH];
                sel_wdata = bus.wdata[WIDTH*c +: WIDTH];
            end
        end
    end

    // Access FSM with registered RAM controls and completion outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_q         <= OP_RD;
            own_q        <= '0;
            fld_ok_q     <= 1'b0;
            cnt          <= '0;
            bus.done     <= 1'b0;
            bus.done_ch  <= '0;
            bus.rdata    <= '0;
            bus.carry    <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            bus.ram_we   <= 1'b0;
        end else begin
            bus.done    <= 1'b0;
            bus.done_ch <= '0;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        own_q        <= gnt;
                        op_q         <= sel_dec;
                        fld_ok_q     <= FIELD_OK[sel_field];
                        bus.ram_addr <= {sel_field, sel_addr};
                        bus.carry    <= 1'b0;
                        if (sel_dec == OP_WR) begin
                            state       <= ST_WR;
                            bus.ram_we  <= FIELD_OK[sel_field];
                            bus.ram_din <= sel_wdata;
                        end else begin
                            state <= ST_RD;
                            cnt   <= CW'(RD_LAT - 1);
                        end
                    end
                end
                ST_RD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (op_q == OP_INC) begin
                        state       <= ST_WR;
                        bus.ram_we  <= fld_ok_q;
                        bus.ram_din <= rd_val + WIDTH'(1);
                        bus.carry   <= &rd_val;
                    end else begin
                        state       <= ST_DONE;
                        bus.done    <= 1'b1;
                        bus.done_ch <= own_q;
                        bus.rdata   <= rd_val;
                    end
                end
                ST_WR: begin
                    // ram_din holds wdata for a write or captured+1 for an increment
                    state       <= ST_DONE;
                    bus.ram_we  <= 1'b0;
                    bus.done    <= 1'b1;
                    bus.done_ch <= own_q;
                    bus.rdata   <= bus.ram_din;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_seq.md
# mem_seq

Parametrised memory access sequencer for the PDP-8e core. It arbitrates between several requesting channels (CPU major-state logic, front panel, data break) and drives one synchronous RAM port. Each access is a read, a write, or an increment (read-modify-write for ISZ and auto-index). The block forms the extended address from a per-request field and emulates nonexistent memory for fields above `MAX_FIELD`.

## Interface
Parameters:
- `WIDTH`, 12, data and in-field address width.
- `FIELD_BITS`, 3, field number width (`EMA`).
- `MAX_FIELD`, 7, highest populated field; must be less than 2**`FIELD_BITS`.
- `NCH`, 2, number of requesting channels; channel 0 has the highest priority.
- `RD_LAT`, 1, RAM read latency in cycles; must be at least 1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req` in `NCH`: per-channel request level. Held until granted.
- `op` in 2*`NCH`: per-channel operation. 00 = read, 01 = write, 10 = increment, 11 = reserved (treated as read).
- `field` in `FIELD_BITS`*`NCH`: per-channel field.
- `addr` in `WIDTH`*`NCH`: per-channel in-field address.
- `wdata` in `WIDTH`*`NCH`: per-channel write data.
- `gnt` out `NCH`: one-hot, one-cycle acceptance pulse.
- `busy` out 1: high from the cycle after `gnt` through the DONE cycle.
- `done` out 1: one-cycle completion pulse.
- `done_ch` out `NCH`: one-hot owner of the completing access, valid with `done`.
- `rdata` out `WIDTH`: result data, valid with `done` and held until the next `done`.
- `carry` out 1: set when an increment wrapped all-ones to 0; valid with `done`.
- `ram_addr` out `FIELD_BITS`+`WIDTH`: `{field, addr}`.
- `ram_din` out `WIDTH`: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_dout` in `WIDTH`: RAM read data, `RD_LAT` cycles after `ram_addr`.

## Operation
- States: IDLE, RD, WR, DONE.
- In IDLE with any `req` bit set, the lowest-index requester wins. Its `gnt` pulses that cycle, and its `op`, `field`, `addr` and `wdata` are latched.
- Transitions out of IDLE: read or increment goes to RD; write goes to WR.
- RD lasts exactly `RD_LAT` cycles, counted by a down-counter. It then captures `ram_dout`, forced to 0 when the field is nonexistent.
- After RD: a read goes to DONE; an increment goes to WR.
- WR lasts 1 cycle:
  - Write: `ram_din` = latched `wdata`.
  - Increment: `ram_din` = captured + 1, mod 2**`WIDTH`; `carry` is set when captured is all-ones.
  - `ram_we` = 1 only if `field` ≤ `MAX_FIELD`.
- DONE lasts 1 cycle and pulses `done` and `done_ch`. It then returns to IDLE, so no grant is issued in DONE.
- `rdata` takes the captured value for a read, captured + 1 for an increment, and `wdata` for a write.
- Nonexistent field (`field` > `MAX_FIELD`):
  - Reads return 0.
  - Increments return 1 with `carry` = 0.
  - No write ever reaches the RAM.
- `ram_addr` is held stable from the first RD/WR cycle through DONE.
- Losing requesters stay pending; they are not latched or queued internally.
- A `req` dropped before its `gnt` is ignored. `req` changes after `gnt` have no effect on the access in progress.

## Timing
- Cycle 0 is the `gnt` cycle.
- Read: RD occupies cycles 1..`RD_LAT`; `done` in cycle `RD_LAT`+1.
- Write: `ram_we` in cycle 1; `done` in cycle 2.
- Increment: `ram_we` in cycle `RD_LAT`+1; `done` in cycle `RD_LAT`+2.
- Minimum gap from one `gnt` to the next is the access latency + 1, because the FSM passes through IDLE.
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset mid-access: the access is abandoned. `ram_we` and `done` are 0 from the cycle after the reset edge, and no partial write is retried.
- `ram_we`, `ram_addr` and `ram_din` are registered outputs.

## Structure
- Shared package: op encodings (`OP_RD`, `OP_WR`, `OP_INC`) and state encodings. `WIDTH` and `FIELD_BITS` defaults mirror the machine-wide constants.
- Sub-module `mem_arb`: a parametrised `NCH` fixed-priority one-hot arbiter, enabled only in IDLE.
- The RAM stays outside this block.

## Test plan
- Read: field 2, addr 0100, RAM holds 1234, `RD_LAT`=2 → `gnt` cycle 0, `done` cycle 3, `rdata`=1234, `ram_addr`={2,0100}.
- Increment of 7777 in field 0 → RAM write 0000 at cycle `RD_LAT`+1, `rdata`=0000, `carry`=1. Increment of 0005 → RAM write 0006, `carry`=0.
- `MAX_FIELD`=3, write to field 5 → `ram_we` never asserted, `done` cycle 2. Read of field 5 → `rdata`=0000. Increment of field 5 → `rdata`=0001.
- `req`=2'b11 in the same cycle → ch0 granted first, `done_ch`=01; ch1 granted in the first IDLE after that, `done_ch`=10.
- `reset` asserted during an increment's RD phase → no `ram_we`, no `done`, all outputs 0. A fresh read afterwards completes normally.
- `NCH`=3, `WIDTH`=16, `RD_LAT`=3: random op stream against a behavioural memory model → every `done` data and `carry` matches the model.
